uart_tx: RTL and testbench

UART transmit serializer; the transmit-side counterpart of the receive deserializer in the same UART. It accepts one parallel byte on a valid strobe, latches it, and emits a standard asynchronous frame on `tx_out`: start bit, eight data bits LSB first, optional parity bit, stop bit. `clk` is the TX bit clock: one bit period per `clk` cycle, generated by the shared clock divider. `busy` tells the upstream FIFO/sync stage when a new byte may be offered.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Parity logic is compiled in only when UART_TX_PARITY_EN is defined; otherwise every frame is 10 bits.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]            r_state;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_shadow;
   logic                  r_tx;
   logic                  r_busy;
   logic [CW-1:0]         w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + 1'b1;

`ifdef UART_TX_PARITY_EN
   logic r_par_en;
   logic r_par_typ;
   logic w_par;

   // Computed from the latched byte so mid-frame input changes cannot leak in.
   assign w_par = (^r_shadow) ^ r_par_typ;
`else
   logic w_unused_par;

   assign w_unused_par = par_en ^ par_typ;
`endif

   // tx_out/busy are registered with the value of the state being entered,
   // so the start bit is on the line from the accepting edge onward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_shadow  <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
               if (data_valid) begin
                  r_shadow  <= p_data;
`ifdef UART_TX_PARITY_EN
                  r_par_en  <= par_en;
                  r_par_typ <= par_typ;
`endif
                  r_state   <= S_START;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            S_START: begin
               r_state <= S_DATA;
               r_cnt   <= '0;
               r_tx    <= r_shadow[0];
               r_busy  <= 1'b1;
            end
            S_DATA: begin
               r_busy <= 1'b1;
               if (r_cnt == C_LAST) begin
`ifdef UART_TX_PARITY_EN
                  if (r_par_en) begin
                     r_state <= S_PARITY;
                     r_tx    <= w_par;
                  end else begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end
`else
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
`endif
               end else begin
                  r_cnt <= w_cnt_nxt;
                  r_tx  <= r_shadow[w_cnt_nxt];
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               r_state <= S_STOP;
               r_tx    <= 1'b1;
               r_busy  <= 1'b1;
            end
`endif
            S_STOP: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_out = r_tx;
   assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random frames checked against a bit-list model of the frame.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx_out;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected line levels for one frame, straight from the frame format.
   function automatic void build_frame(input logic [7:0] d, input bit pe, input bit pt,
                                       output bit bits[$]);
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(bit'((d >> i) & 8'd1));
      if (PAR_BUILT && pe) bits.push_back(bit'(($countones(d) % 2) ^ int'(pt)));
      bits.push_back(1'b1);
   endfunction

   // Call at a negedge; returns at the negedge of the first idle cycle after the frame.
   // noise: 0 quiet inputs, 1 random inputs mid-frame, 2 single 8'hFF request at cycle 3.
   task automatic send(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                       input int noise);
      bit bits[$];
      build_frame(d, pe, pt, bits);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      for (int k = 0; k < bits.size(); k++) begin
         @(negedge clk);
         data_valid = 1'b0;
         if (noise == 1) begin
            data_valid = 1'($urandom_range(0, 1));
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
         end else if (noise == 2 && k == 3) begin
            data_valid = 1'b1;
            p_data     = 8'hFF;
         end
         check($sformatf("%s bit%0d tx", tag, k), tx_out, logic'(bits[k]));
         check($sformatf("%s bit%0d busy", tag, k), busy, 1'b1);
      end
      @(negedge clk);
      data_valid = 1'b0;
      check($sformatf("%s idle tx", tag), tx_out, 1'b1);
      check($sformatf("%s idle busy", tag), busy, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      check("reset tx", tx_out, 1'b1);
      check("reset busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset tx", tx_out, 1'b1);
      check("post-reset busy", busy, 1'b0);

      // Directed frames from the test plan
      send("A5 nopar", 8'hA5, 1'b0, 1'b0, 0);
      send("A5 even", 8'hA5, 1'b1, 1'b0, 0);
      send("07 odd", 8'h07, 1'b1, 1'b1, 0);
      send("07 even", 8'h07, 1'b1, 1'b0, 0);
      send("00 midreq", 8'h00, 1'b0, 1'b0, 2);
      @(negedge clk);
      check("dropped req tx", tx_out, 1'b1);
      check("dropped req busy", busy, 1'b0);
      send("FF later", 8'hFF, 1'b0, 1'b0, 0);

      // Random frames, some back-to-back at minimum spacing, with mid-frame noise
      for (int n = 0; n < 24; n++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check($sformatf("rnd%0d gap%0d tx", n, g), tx_out, 1'b1);
            check($sformatf("rnd%0d gap%0d busy", n, g), busy, 1'b0);
         end
         send($sformatf("rnd%0d", n), 8'($urandom), 1'($urandom), 1'($urandom), 1);
      end

      // Reset in the middle of a data bit
      p_data = 8'h00; par_en = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset busy", busy, 1'b1);
      check("pre-reset tx", tx_out, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async reset tx", tx_out, 1'b1);
      check("async reset busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after reset tx", tx_out, 1'b1);
      check("after reset busy", busy, 1'b0);
      send("3C after reset", 8'h3C, 1'b1, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
